// File: rtl/bus_sram_slave.sv
// Bus slave that maps a word-addressed synchronous SRAM into a fixed byte region.
// It supports burst reads and writes with per-lane write enables, read stalls and aborts.
module bus_sram_slave #(
    parameter logic [31:0] BASE_ADDRESS = 32'h4000_0000,
    parameter int          DEPTH_WORDS  = 256
) (
    input  logic        system_clock,
    input  logic        system_reset,
    input  logic [31:0] address_dataIN,
    input  logic [3:0]  byte_enableIN,
    input  logic [7:0]  burst_sizeIN,
    input  logic        read_n_writeIN,
    input  logic        begin_transactionIN,
    input  logic        end_transactionIN,
    input  logic        data_validIN,
    input  logic        busyIN,
    output logic [31:0] address_dataOUT,
    output logic        end_transactionOUT,
    output logic        data_validOUT,
    output logic        busyOUT,
    output logic        errorOUT
);

    // state    | meaning
    // ST_IDLE  | no transaction owned, outputs 0, waiting for a region hit
    // ST_WRITE | accepting write beats until end_transactionIN
    // ST_READ  | fetching and presenting read words, honouring busyIN
    // ST_END   | last read word on the bus; end pulse follows
    // ST_ERROR | burst overran the region; error and end pulse on the bus

    localparam int IDX_W   = $clog2(DEPTH_WORDS);
    localparam int RGN_LSB = IDX_W + 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_READ,
        ST_END,
        ST_ERROR
    } state_t;

    state_t           state, state_nxt;
    logic [IDX_W-1:0] ptr, ptr_nxt;
    logic [8:0]       left, left_nxt;
    logic [8:0]       pend, pend_nxt;
    logic             q_valid, q_valid_nxt;
    logic [3:0]       be_r, be_nxt;
    logic [31:0]      data_q, data_nxt;
    logic             dv_q, dv_nxt;
    logic             end_q, end_nxt;
    logic             err_q, err_nxt;

    logic [31:0]      mem [DEPTH_WORDS];
    logic [31:0]      ram_q;
    logic             ram_re;
    logic [IDX_W-1:0] ram_raddr;
    logic             mem_we;

    logic             hit;
    logic [IDX_W-1:0] idx_in;
    logic [31:0]      span;
    logic             overflow;
    logic             consume;

    assign hit      = begin_transactionIN &&
                      (address_dataIN[31:RGN_LSB] == BASE_ADDRESS[31:RGN_LSB]);
    assign idx_in   = address_dataIN[RGN_LSB-1:2];
    assign span     = 32'(idx_in) + 32'(burst_sizeIN);
    assign overflow = span > 32'(DEPTH_WORDS - 1);
    assign consume  = q_valid && !busyIN;

    always_comb begin
        state_nxt   = state;
        ptr_nxt     = ptr;
        left_nxt    = left;
        pend_nxt    = pend;
        q_valid_nxt = q_valid;
        be_nxt      = be_r;
        data_nxt    = '0;
        dv_nxt      = 1'b0;
        end_nxt     = 1'b0;
        err_nxt     = 1'b0;
        ram_re      = 1'b0;
        ram_raddr   = ptr;
        mem_we      = 1'b0;

        case (state)
            ST_IDLE: begin
                if (hit) begin
                    if (overflow) begin
                        state_nxt = ST_ERROR;
                        err_nxt   = 1'b1;
                        end_nxt   = 1'b1;
                    end else if (read_n_writeIN) begin
                        // First word is fetched straight from the begin address.
                        state_nxt   = ST_READ;
                        ram_re      = 1'b1;
                        ram_raddr   = idx_in;
                        ptr_nxt     = idx_in + IDX_W'(1);
                        left_nxt    = {1'b0, burst_sizeIN};
                        pend_nxt    = {1'b0, burst_sizeIN} + 9'd1;
                        q_valid_nxt = 1'b1;
                    end else begin
                        state_nxt = ST_WRITE;
                        ptr_nxt   = idx_in;
                        left_nxt  = {1'b0, burst_sizeIN} + 9'd1;
                        be_nxt    = byte_enableIN;
                    end
                end
            end
            ST_WRITE: begin
                if (end_transactionIN) begin
                    state_nxt = ST_IDLE;
                    left_nxt  = '0;
                end else if (data_validIN && (left != '0)) begin
                    mem_we   = system_reset;
                    ptr_nxt  = ptr + IDX_W'(1);
                    left_nxt = left - 9'd1;
                end
            end
            ST_READ: begin
                if (end_transactionIN) begin
                    state_nxt   = ST_IDLE;
                    left_nxt    = '0;
                    pend_nxt    = '0;
                    q_valid_nxt = 1'b0;
                end else begin
                    if (consume) begin
                        dv_nxt      = 1'b1;
                        data_nxt    = ram_q;
                        pend_nxt    = pend - 9'd1;
                        q_valid_nxt = 1'b0;
                        if (pend == 9'd1) begin
                            state_nxt = ST_END;
                        end
                    end
                    // The RAM output register doubles as the stall buffer.
                    if ((left != '0) && (!q_valid || consume)) begin
                        ram_re      = 1'b1;
                        ram_raddr   = ptr;
                        ptr_nxt     = ptr + IDX_W'(1);
                        left_nxt    = left - 9'd1;
                        q_valid_nxt = 1'b1;
                    end
                end
            end
            ST_END: begin
                end_nxt   = 1'b1;
                state_nxt = ST_IDLE;
            end
            ST_ERROR: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge system_clock) begin
        if (!system_reset) begin
            state   <= ST_IDLE;
            ptr     <= '0;
            left    <= '0;
            pend    <= '0;
            q_valid <= 1'b0;
            be_r    <= '0;
            data_q  <= '0;
            dv_q    <= 1'b0;
            end_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state   <= state_nxt;
            ptr     <= ptr_nxt;
            left    <= left_nxt;
            pend    <= pend_nxt;
            q_valid <= q_valid_nxt;
            be_r    <= be_nxt;
            data_q  <= data_nxt;
            dv_q    <= dv_nxt;
            end_q   <= end_nxt;
            err_q   <= err_nxt;
        end
    end

    always_ff @(posedge system_clock) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (be_r[i]) begin
                    mem[ptr][8*i +: 8] <= address_dataIN[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge system_clock) begin
        if (ram_re) begin
            ram_q <= mem[ram_raddr];
        end
    end

    assign address_dataOUT    = data_q;
    assign data_validOUT      = dv_q;
    assign end_transactionOUT = end_q;
    assign errorOUT           = err_q;
    assign busyOUT            = 1'b0;

endmodule

// File: tb/tb_bus_sram_slave.sv
// Randomized bench for bus_sram_slave: a cycle-indexed expectation table built from a
// word-array memory model, checked every cycle, plus literal checks on directed scenarios.
module tb_bus_sram_slave;

    localparam int          MAXC = 20000;
    localparam logic [31:0] BASE = 32'h4000_0000;

    logic        system_clock = 1'b0;
    logic        system_reset;
    logic [31:0] address_dataIN;
    logic [3:0]  byte_enableIN;
    logic [7:0]  burst_sizeIN;
    logic        read_n_writeIN;
    logic        begin_transactionIN;
    logic        end_transactionIN;
    logic        data_validIN;
    logic        busyIN;
    logic [31:0] address_dataOUT;
    logic        end_transactionOUT;
    logic        data_validOUT;
    logic        busyOUT;
    logic        errorOUT;

    bus_sram_slave #(.BASE_ADDRESS(BASE), .DEPTH_WORDS(256)) dut (
        .system_clock        (system_clock),
        .system_reset        (system_reset),
        .address_dataIN      (address_dataIN),
        .byte_enableIN       (byte_enableIN),
        .burst_sizeIN        (burst_sizeIN),
        .read_n_writeIN      (read_n_writeIN),
        .begin_transactionIN (begin_transactionIN),
        .end_transactionIN   (end_transactionIN),
        .data_validIN        (data_validIN),
        .busyIN              (busyIN),
        .address_dataOUT     (address_dataOUT),
        .end_transactionOUT  (end_transactionOUT),
        .data_validOUT       (data_validOUT),
        .busyOUT             (busyOUT),
        .errorOUT            (errorOUT)
    );

    always #5 system_clock = ~system_clock;

    int cyc = 0;
    always @(posedge system_clock) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    logic [31:0] mem_m [256];
    bit   [31:0] exp_data [MAXC];
    bit          exp_dv   [MAXC];
    bit          exp_end  [MAXC];
    bit          exp_err  [MAXC];

    int          rec_dv_cyc [$];
    logic [31:0] rec_dv_data [$];
    int          rec_end_cyc [$];
    int          rec_err_cyc [$];
    logic [31:0] wr_q [$];

    // Every cycle: the whole output bundle against the expectation table.
    always @(negedge system_clock) begin : cmp_proc
        logic [35:0] act, req;
        if (cyc >= 1 && cyc < MAXC) begin
            act = {data_validOUT, end_transactionOUT, errorOUT, busyOUT, address_dataOUT};
            req = {exp_dv[cyc], exp_end[cyc], exp_err[cyc], 1'b0, exp_data[cyc]};
            total++;
            if (act !== req) begin
                bad++;
                $display("FAIL outputs@cyc%0d: got dv=%b end=%b err=%b busy=%b data=%h, want dv=%b end=%b err=%b busy=0 data=%h",
                         cyc, act[35], act[34], act[33], act[32], act[31:0],
                         req[35], req[34], req[33], req[31:0]);
            end
        end
        if (data_validOUT === 1'b1) begin
            rec_dv_cyc.push_back(cyc);
            rec_dv_data.push_back(address_dataOUT);
        end
        if (end_transactionOUT === 1'b1) rec_end_cyc.push_back(cyc);
        if (errorOUT === 1'b1) rec_err_cyc.push_back(cyc);
    end

    initial begin
        #(MAXC * 10);
        $display("FAIL watchdog: got cyc=%0d, want finish before %0d", cyc, MAXC);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, req);
        end
    endtask

    function automatic bit is_hit(input logic [31:0] a);
        return (a & 32'hFFFF_FC00) == BASE;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    task automatic next_cycle();
        @(posedge system_clock);
        #1;
        system_reset        = 1'b1;
        begin_transactionIN = 1'b0;
        end_transactionIN   = 1'b0;
        data_validIN        = 1'b0;
        busyIN              = 1'b0;
        address_dataIN      = $urandom;
        byte_enableIN       = 4'($urandom);
        burst_sizeIN        = 8'($urandom);
        read_n_writeIN      = 1'($urandom);
    endtask

    task automatic clear_rec();
        rec_dv_cyc.delete();
        rec_dv_data.delete();
        rec_end_cyc.delete();
        rec_err_cyc.delete();
    endtask

    task automatic settle();
        repeat (3) next_cycle();
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [3:0] be, input int burst,
                            input int abort_beat, input bit gaps, output int b);
        int idx, n, beats, extra;
        logic [31:0] d;
        next_cycle();
        b = cyc;
        begin_transactionIN = 1'b1;
        address_dataIN      = addr;
        byte_enableIN       = be;
        burst_sizeIN        = 8'(burst);
        read_n_writeIN      = 1'b0;
        idx = int'(addr[9:2]);
        if (!is_hit(addr)) begin
            repeat (3) begin
                next_cycle();
                data_validIN = 1'b1;
            end
            return;
        end
        if (idx + burst > 255) begin
            exp_err[b+1] = 1'b1;
            exp_end[b+1] = 1'b1;
            next_cycle();
            return;
        end
        n     = burst + 1;
        beats = 0;
        extra = gaps ? int'($urandom_range(0, 2)) : 0;
        forever begin
            next_cycle();
            if (abort_beat >= 0 && beats == abort_beat) begin
                end_transactionIN = 1'b1;
                break;
            end
            if (beats == n && extra == 0) begin
                end_transactionIN = 1'b1;
                break;
            end
            begin_transactionIN = ($urandom_range(0, 7) == 0);
            if (gaps && $urandom_range(0, 2) == 0) continue;
            d = (wr_q.size() > 0) ? wr_q.pop_front() : $urandom;
            data_validIN   = 1'b1;
            address_dataIN = d;
            if (beats < n) begin
                mem_m[idx+beats] = merge(mem_m[idx+beats], d, be);
                beats++;
            end else begin
                extra--;
            end
        end
    endtask

    // busy_mode: 0 never, 1 random, 2 three stall cycles once two words are out
    task automatic do_read(input logic [31:0] addr, input int burst, input int busy_mode,
                           input int abort_word, input int reset_word, output int b);
        int idx, n, k, stall, iter, c;
        next_cycle();
        b = cyc;
        begin_transactionIN = 1'b1;
        address_dataIN      = addr;
        burst_sizeIN        = 8'(burst);
        read_n_writeIN      = 1'b1;
        busyIN              = 1'($urandom_range(0, 1));
        idx = int'(addr[9:2]);
        if (!is_hit(addr)) begin
            repeat (3) next_cycle();
            return;
        end
        if (idx + burst > 255) begin
            exp_err[b+1] = 1'b1;
            exp_end[b+1] = 1'b1;
            next_cycle();
            return;
        end
        n = burst + 1;
        k = 0;
        stall = 0;
        iter = 0;
        forever begin
            next_cycle();
            c = cyc;
            iter++;
            if (k == n) break;
            if (abort_word >= 0 && k == abort_word) begin
                end_transactionIN = 1'b1;
                break;
            end
            if (reset_word >= 0 && k == reset_word) begin
                system_reset = 1'b0;
                break;
            end
            case (busy_mode)
                1: busyIN = ($urandom_range(0, 2) == 0);
                2: if (k == 2 && stall < 3) begin
                       busyIN = 1'b1;
                       stall++;
                   end
                default: ;
            endcase
            if (iter > 8 * n + 20) busyIN = 1'b0;
            begin_transactionIN = ($urandom_range(0, 7) == 0);
            if (!busyIN) begin
                exp_dv[c+1]   = 1'b1;
                exp_data[c+1] = mem_m[idx+k];
                k++;
                if (k == n) exp_end[c+2] = 1'b1;
            end
        end
    endtask

    initial begin
        int          b, sel, idx, burst, abort;
        logic [31:0] addr, saved;
        logic [31:0] lit4 [4];

        system_reset        = 1'b0;
        begin_transactionIN = 1'b0;
        end_transactionIN   = 1'b0;
        data_validIN        = 1'b0;
        busyIN              = 1'b0;
        address_dataIN      = '0;
        byte_enableIN       = '0;
        burst_sizeIN        = '0;
        read_n_writeIN      = 1'b0;
        repeat (3) begin
            next_cycle();
            system_reset = 1'b0;
        end
        @(negedge system_clock);
        chk("reset_outputs", {data_validOUT, end_transactionOUT, errorOUT, busyOUT, address_dataOUT}, '0);

        // Fill the whole region with one 256-word burst so every word is known.
        do_write(BASE, 4'hF, 255, -1, 1'b0, b);
        do_read(BASE, 255, 1, -1, -1, b);

        // Write-then-read of four words.
        wr_q = '{32'h11, 32'h22, 32'h33, 32'h44};
        do_write(32'h4000_0010, 4'hF, 3, -1, 1'b0, b);
        chk("model_pin_word4", mem_m[4], 32'h11);
        chk("model_pin_word7", mem_m[7], 32'h44);
        clear_rec();
        do_read(32'h4000_0010, 3, 0, -1, -1, b);
        settle();
        lit4 = '{32'h11, 32'h22, 32'h33, 32'h44};
        chk("wr_rd_count", rec_dv_cyc.size(), 4);
        for (int i = 0; i < 4 && i < rec_dv_cyc.size(); i++) begin
            chk("wr_rd_latency", rec_dv_cyc[i] - b, 2 + i);
            chk("wr_rd_data", rec_dv_data[i], lit4[i]);
        end
        chk("wr_rd_end_count", rec_end_cyc.size(), 1);
        if (rec_end_cyc.size() > 0) chk("wr_rd_end_cycle", rec_end_cyc[0] - b, 6);

        // Byte enables.
        wr_q = '{32'h0};
        do_write(BASE, 4'hF, 0, -1, 1'b0, b);
        wr_q = '{32'hAABB_CCDD};
        do_write(BASE, 4'b0101, 0, -1, 1'b0, b);
        chk("model_pin_be", mem_m[0], 32'h00BB_00DD);
        clear_rec();
        do_read(BASE, 0, 0, -1, -1, b);
        settle();
        chk("be_count", rec_dv_data.size(), 1);
        if (rec_dv_data.size() > 0) chk("be_data", rec_dv_data[0], 32'h00BB_00DD);

        // Overflow at the top word.
        saved = mem_m[255];
        clear_rec();
        do_write(32'h4000_03FC, 4'hF, 1, -1, 1'b0, b);
        settle();
        chk("ovf_err_count", rec_err_cyc.size(), 1);
        chk("ovf_end_count", rec_end_cyc.size(), 1);
        if (rec_err_cyc.size() > 0) chk("ovf_err_cycle", rec_err_cyc[0] - b, 1);
        if (rec_end_cyc.size() > 0) chk("ovf_end_cycle", rec_end_cyc[0] - b, 1);
        chk("ovf_no_data", rec_dv_cyc.size(), 0);
        clear_rec();
        do_read(32'h4000_03FC, 0, 0, -1, -1, b);
        settle();
        chk("ovf_mem_count", rec_dv_data.size(), 1);
        if (rec_dv_data.size() > 0) chk("ovf_mem_unchanged", rec_dv_data[0], saved);

        // Region miss.
        clear_rec();
        do_write(32'h5000_0000, 4'hF, 3, -1, 1'b0, b);
        repeat (10) next_cycle();
        chk("miss_dv", rec_dv_cyc.size(), 0);
        chk("miss_end", rec_end_cyc.size(), 0);
        chk("miss_err", rec_err_cyc.size(), 0);

        // Eight-word read with a three-cycle stall after the second word.
        clear_rec();
        do_read(32'h4000_0040, 7, 2, -1, -1, b);
        settle();
        chk("stall_count", rec_dv_cyc.size(), 8);
        for (int i = 0; i < 8 && i < rec_dv_cyc.size(); i++) begin
            chk("stall_data", rec_dv_data[i], mem_m[16+i]);
            chk("stall_cycle", rec_dv_cyc[i] - b, (i < 2) ? 2 + i : 5 + i);
        end

        // Reset at word 3, then a fresh transaction.
        clear_rec();
        do_read(32'h4000_0080, 7, 0, -1, 3, b);
        settle();
        chk("rst_words", rec_dv_cyc.size(), 3);
        chk("rst_no_end", rec_end_cyc.size(), 0);
        clear_rec();
        do_read(32'h4000_0080, 1, 0, -1, -1, b);
        settle();
        chk("rst_after_words", rec_dv_cyc.size(), 2);

        // Abort at word 3, then a fresh write and read.
        clear_rec();
        do_read(32'h4000_0100, 7, 0, 3, -1, b);
        settle();
        chk("abort_words", rec_dv_cyc.size(), 3);
        chk("abort_no_end", rec_end_cyc.size(), 0);
        do_write(32'h4000_0100, 4'hF, 2, -1, 1'b1, b);
        clear_rec();
        do_read(32'h4000_0100, 2, 0, -1, -1, b);
        settle();
        chk("abort_after_words", rec_dv_cyc.size(), 3);

        for (int t = 0; t < 80; t++) begin
            sel = int'($urandom_range(0, 9));
            if (sel == 0) begin
                burst = int'($urandom_range(0, 15));
                addr  = $urandom;
                if (is_hit(addr)) addr = addr ^ 32'h8000_0000;
            end else if (sel == 1) begin
                idx   = int'($urandom_range(240, 255));
                burst = (256 - idx) + int'($urandom_range(0, 10));
                addr  = BASE | 32'(idx << 2);
            end else begin
                burst = int'($urandom_range(0, 15));
                idx   = int'($urandom_range(0, 255 - burst));
                addr  = BASE | 32'(idx << 2) | 32'($urandom_range(0, 3));
            end
            abort = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, burst)) : -1;
            if ($urandom_range(0, 1) == 1) do_read(addr, burst, 1, abort, -1, b);
            else do_write(addr, 4'($urandom), burst, abort, 1'b1, b);
            repeat ($urandom_range(0, 2)) next_cycle();
        end
        settle();

        chk("cycle_budget", cyc < MAXC, 1'b1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bus_sram_slave.md
BUS_SRAM_SLAVE -- requirements
Module: bus_sram_slave

Interface
REQ-001 SHALL have parameter BASE_ADDRESS, default 32'h4000_0000, the byte base of the slave region, aligned to the region size.
REQ-002 SHALL have parameter DEPTH_WORDS, default 256, giving the number of 32-bit words (power of 2); the region spans DEPTH_WORDS*4 bytes.
REQ-003 SHALL have port system_clock, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 SHALL have port system_reset, input, 1 bit: reset is synchronous and active-low.
REQ-005 SHALL have port address_dataIN, input, 32 bits: address at begin, write data during the burst.
REQ-006 SHALL have port byte_enableIN, input, 4 bits: write byte lanes, sampled at begin.
REQ-007 SHALL have port burst_sizeIN, input, 8 bits: number of words minus 1, sampled at begin.
REQ-008 SHALL have port read_n_writeIN, input, 1 bit: 1 means read, 0 means write, sampled at begin.
REQ-009 SHALL have ports begin_transactionIN, end_transactionIN, data_validIN and busyIN, each input, 1 bit: the master's bus control; busyIN stalls read data.
REQ-010 SHALL have port address_dataOUT, output, 32 bits: read data.
REQ-011 SHALL have ports end_transactionOUT, data_validOUT, busyOUT and errorOUT, each output, 1 bit: the slave's bus responses.

Function
REQ-012 SHALL drive all outputs to 0 in every cycle it is not owning a transaction, so the outputs are OR-combinable on the bus.
REQ-013 SHALL implement FSM states IDLE, WRITE, READ, END, ERROR; every transition is on the rising edge.
REQ-014 SHALL, in IDLE on begin_transactionIN=1, decode a region hit as address_dataIN[31:log2(DEPTH_WORDS*4)] equal to the same bits of BASE_ADDRESS; a miss keeps IDLE with no response.
REQ-015 SHALL, on a hit, capture the word index (address bits [log2(DEPTH_WORDS)+1:2]), burst_sizeIN, byte_enableIN and read_n_writeIN; address bits [1:0] are ignored.
REQ-016 SHALL go to ERROR when word index + burst_size > DEPTH_WORDS-1, computed in 9+ bits without wrap; otherwise it SHALL go to WRITE or READ.
REQ-017 SHALL, in ERROR, assert errorOUT=1 and end_transactionOUT=1 together for exactly one cycle, then return to IDLE; memory is not modified.
REQ-018 SHALL, in WRITE, hold busyOUT=0 and store address_dataIN on each data_validIN=1 cycle, updating only the enabled bytes, then increment the index and decrement the remaining count.
REQ-019 SHALL ignore data_validIN beats beyond burst_size+1 and, after the final beat, stay in WRITE until end_transactionIN=1, then go to IDLE.
REQ-020 SHALL, in READ, launch its first word with data_validOUT=1 exactly 2 cycles after the begin cycle (1-cycle synchronous RAM latency plus the output register).
REQ-021 SHALL drive data_validOUT high for exactly one cycle per word, with address_dataOUT valid in that cycle and 0 otherwise.
REQ-022 SHALL, if busyIN=1 in cycle t, present no new word in cycle t+1; the pending word is held internally and presented in the first cycle after busyIN returns to 0, so no word is lost or duplicated.
REQ-023 SHALL, after the last read word, enter END, assert end_transactionOUT=1 for exactly one cycle, then go to IDLE; the write path SHALL never assert end_transactionOUT.
REQ-024 SHALL, on end_transactionIN=1 while in WRITE or READ before completion, abort to IDLE the next cycle with no further data, no end_transactionOUT and no further memory writes.
REQ-025 SHALL ignore begin_transactionIN outside IDLE.
REQ-026 SHALL treat burst_size=255 as legal (256 words) when it fits the region.

Reset
REQ-027 SHALL, when system_reset=0 at a clock edge, set the state to IDLE, all outputs to 0 and the counters to 0; memory contents are undefined and not cleared.
REQ-028 SHALL, on reset asserted mid-burst, abandon the burst with no end_transactionOUT and have all outputs at 0 in the cycle after the reset edge.

Verification
REQ-029 SHALL pass a write-then-read test: write a 4-word burst at 0x4000_0010 (be=4'hF, data 0x11,0x22,0x33,0x44), then read it back -> data_validOUT at begin+2..begin+5 carrying 0x11..0x44, then end_transactionOUT for one cycle.
REQ-030 SHALL pass a byte-enable test: write 0xAABBCCDD with be=4'b0101 over 0x0 at 0x4000_0000, then read -> 0x00BB00DD.
REQ-031 SHALL pass an overflow test: begin at 0x4000_03FC with burst_size=1 -> errorOUT=1 and end_transactionOUT=1 for one cycle, then memory is unchanged.
REQ-032 SHALL pass a miss test: begin at 0x5000_0000 -> all outputs stay 0 for 10 cycles.
REQ-033 SHALL pass a stall test: read 8 words with busyIN=1 for 3 cycles after word 2 -> exactly 8 data_validOUT pulses, in order, with no duplicates.
REQ-034 SHALL pass a reset/abort test: system_reset=0 mid-read at word 3 and, separately, end_transactionIN at word 3 -> outputs at 0 next cycle, and a new transaction is accepted thereafter.
